des_key_sched: RTL and testbench
================================

# des_key_sched

Sequential DES key-schedule generator for the iterative datapath. It accepts a 64-bit key, applies PC-1, and then produces the sixteen 48-bit round subkeys one at a time through a valid/ready handshake. Each subkey drives the `K` input of the round-function stage directly. Subkeys come out in encrypt order (K1..K16) or decrypt order (K16..K1), chosen per key load.

## Interface
- Parameters: none (DES constants fixed in package).
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  load request; accepted only in IDLE.
- `key`  in  64  key `[64:1]`, index 64 = DES bit 1 (MSB-first, DES bit n at index 65-n); sampled on the accepting edge.
- `decrypt`  in  1  0 = K1..K16 order, 1 = K16..K1; sampled with `key`.
- `K`  out  48  current subkey `[48:1]`, index 48 = DES PC-2 bit 1 (`K[48:43]` feeds S1).
- `k_valid`  out  1  `K` holds a valid subkey.
- `k_ready`  in  1  consumer accepts `K` this cycle.
- `round`  out  4  DES round index of `K`, 1..16 (encoding 0 = 16).
- `busy`  out  1  not in IDLE.
- `done`  out  1  one-cycle pulse after the 16th subkey is accepted.
- `key_err`  out  1  parity failure flag (macro-dependent, see Configuration).

## Operation
- States: IDLE, RUN.
- IDLE + `start`: C,D (28 b each) ← PC-1(`key`), pre-shifted for the first subkey. Encrypt: rotate left 1. Decrypt: no shift. Then go to RUN with `k_valid`=1 and `cnt`=1.
- RUN: `K` = PC-2(C,D), pure wiring off the registers. A transfer occurs on an edge where `k_valid & k_ready`.
- On each transfer with `cnt`<16: `cnt`+1, C and D rotate independently.
  - Encrypt: left by 1 if the next DES round ∈ {1,2,9,16}, else left by 2.
  - Decrypt: right by 1 if the current DES round ∈ {16,9,2}, else right by 2.
- On the transfer with `cnt`=16: go to IDLE, drop `k_valid`, pulse `done`.
- `round` = `cnt` in encrypt mode, 17−`cnt` in decrypt mode.
- Without a handshake, C, D, `cnt` and `K` are held stable indefinitely. Stalls of any length are legal.
- `start` while `busy` is ignored; no queueing.
- Rotations are modulo 28 within each half and never cross between C and D.

## Timing
- Reset values: state=IDLE, C=D=0, `cnt`=0, `k_valid`=0, `busy`=0, `done`=0, `key_err`=0. `K` therefore equals PC-2(0)=0 and `round`=0.
- Latency: `start` accepted at edge t → `k_valid`=1, `busy`=1 after t, with K of the first round valid.
- Throughput: one subkey per cycle with `k_ready` held high. The 16 subkeys are valid in the 16 cycles after t.
- After the 16th accepting edge: `busy`=0, `k_valid`=0, `done`=1 for exactly one cycle.
- A new `start` is accepted in that same `done` cycle.
- Reset mid-run: asynchronously forces the IDLE values above. No partial `done` is produced.
- `start` and the 16th transfer on the same edge: `start` is ignored, because the FSM is still in RUN on that edge.

## Configuration
- Macro: `DES_KS_PARITY_CHECK_EN`.
- Defined:
  - On `start`, check that each key byte has odd parity (bits 8,16,…,64 counting MSB-first as DES bits).
  - On failure: do not leave IDLE, set `key_err`=1.
  - `key_err` clears on the next accepted `start` or on `rst`.
- Undefined: parity bits are ignored (PC-1 discards them anyway) and `key_err` is tied to 0.

## Structure
- Shared package `des_pkg` holds:
  - PC-1 and PC-2 tables as index constants;
  - the 16-entry shift schedule {1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  - the FSM state typedef;
  - the DES bit-numbering helper.
- One combinational sub-module, `des_pc2`: 56→48 selection, reusable by an unrolled schedule later.
- PC-1 is inlined in the top.

## Test plan
- Encrypt, `k_ready`=1, key 133457799BBCDFF1: first `K`=1B02EFFC7072 with `round`=1. 16th `K`=CB3D8B0E17F5 with `round`=16. `done` one cycle after, i.e. 17 cycles after the start edge.
- Decrypt, same key: first `K`=CB3D8B0E17F5 with `round`=16, last `K`=1B02EFFC7072. The full sequence is the exact reverse of the encrypt capture.
- Encrypt, `k_ready` toggled randomly with 10-cycle stalls: `K`/`round` stable during stalls. The sequence matches the unstalled run, and exactly 16 transfers occur.
- Pulse `start` with a different key at round 7: it is ignored and the subkeys continue from the original key. Assert `rst` at round 9: all outputs return to reset values immediately, without waiting for a clock edge.
- With `DES_KS_PARITY_CHECK_EN`, key 133457799BBCDFF0: `key_err`=1 and `busy` stays 0. A following `start` with 133457799BBCDFF1 clears `key_err` and runs normally. Without the macro, the bad-parity key produces the same subkeys as the good one.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 index tables, the shift schedule,
// the scheduler FSM state type and the MSB-first DES bit-numbering helper.
package des_pkg;

   typedef enum logic {ST_IDLE, ST_RUN} ks_state_t;

   // Entry i holds the DES input bit number that becomes output bit i+1.
   localparam int unsigned PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int unsigned PC2 [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   localparam int unsigned SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   // Vector index of DES bit n in a [width:1] vector where DES bit 1 is the MSB.
   function automatic int unsigned des_idx(input int unsigned n, input int unsigned width);
      return width + 1 - n;
   endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 selection: 56-bit C||D to the 48-bit round subkey, pure wiring.
module des_pc2
   import des_pkg::*;
(
   input  logic [56:1] cd,
   output logic [48:1] k
);

   for (genvar n = 1; n <= 48; n++) begin : g_bit
      assign k[des_idx(n, 48)] = cd[des_idx(PC2[n-1], 56)];
   end

endmodule

// File: rtl/des_key_sched.sv
// Sequential DES key schedule: one 48-bit subkey per handshake, encrypt or decrypt order.
// Optional key parity check enabled by defining DES_KS_PARITY_CHECK_EN.
module des_key_sched
   import des_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [64:1] key,
   input  logic        decrypt,
   output logic [48:1] K,
   output logic        k_valid,
   input  logic        k_ready,
   output logic [3:0]  round,
   output logic        busy,
   output logic        done,
   output logic        key_err
);

   ks_state_t   state, state_nxt;
   logic [28:1] c, d;
   logic [4:0]  cnt;
   logic        dec_mode;
   logic [56:1] pc1_cd;
   logic        parity_ok;
   logic        load, adv, fin;
   logic [3:0]  sh_idx;
   logic        two_step;

   function automatic logic [28:1] rot_half(input logic [28:1] h, input logic right,
                                            input logic two);
      logic [28:1] r;
      case ({right, two})
         2'b00:   r = {h[27:1], h[28]};
         2'b01:   r = {h[26:1], h[28:27]};
         2'b10:   r = {h[1], h[28:2]};
         default: r = {h[2:1], h[28:3]};
      endcase
      return r;
   endfunction

   for (genvar i = 1; i <= 56; i++) begin : g_pc1
      assign pc1_cd[des_idx(i, 56)] = key[des_idx(PC1[i-1], 64)];
   end

`ifdef DES_KS_PARITY_CHECK_EN
   logic [7:0] byte_odd;
   for (genvar b = 0; b < 8; b++) begin : g_par
      assign byte_odd[b] = ^key[8*b+8:8*b+1];
   end
   assign parity_ok = &byte_odd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         key_err <= 1'b0;
      else if (state == ST_IDLE && start)
         key_err <= !parity_ok;
   end
`else
   logic [7:0] unused_parity_bits;
   for (genvar b = 0; b < 8; b++) begin : g_par
      assign unused_parity_bits[b] = key[8*b+1];
   end
   assign parity_ok = 1'b1;
   assign key_err   = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      adv       = 1'b0;
      fin       = 1'b0;
      k_valid   = 1'b0;
      busy      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && parity_ok) begin
               load      = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            k_valid = 1'b1;
            busy    = 1'b1;
            if (k_ready) begin
               if (cnt == 5'd16) begin
                  fin       = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  adv = 1'b1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Encrypt looks up the shift of the next round (index cnt); decrypt undoes the
   // shift of the current round 17-cnt, i.e. index 16-cnt, which is -cnt mod 16.
   assign sh_idx   = dec_mode ? (4'd0 - cnt[3:0]) : cnt[3:0];
   assign two_step = (SHIFTS[sh_idx] == 2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c        <= '0;
         d        <= '0;
         cnt      <= '0;
         dec_mode <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= fin;
         if (load) begin
            dec_mode <= decrypt;
            cnt      <= 5'd1;
            c        <= decrypt ? pc1_cd[56:29] : rot_half(pc1_cd[56:29], 1'b0, 1'b0);
            d        <= decrypt ? pc1_cd[28:1]  : rot_half(pc1_cd[28:1], 1'b0, 1'b0);
         end else if (adv) begin
            cnt <= cnt + 5'd1;
            c   <= rot_half(c, dec_mode, two_step);
            d   <= rot_half(d, dec_mode, two_step);
         end
      end
   end

   // 17-cnt and cnt both wrap 16 to 0 in four bits.
   assign round = dec_mode ? (4'd1 - cnt[3:0]) : cnt[3:0];

   des_pc2 u_pc2 (
      .cd ({c, d}),
      .k  (K)
   );

endmodule

// File: tb/tb_des_key_sched.sv
// Scoreboard bench for des_key_sched: reference subkeys from cumulative PC-1 rotations.
module tb_des_key_sched;

   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };
   localparam int PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };
   localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   localparam logic [64:1] KEY     = 64'h133457799BBCDFF1;
   localparam logic [64:1] BAD_KEY = 64'h133457799BBCDFF0;
   localparam logic [48:1] SK1     = 48'h1B02EFFC7072;
   localparam logic [48:1] SK16    = 48'hCB3D8B0E17F5;

   typedef struct {
      logic [48:1] k;
      logic [3:0]  r;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, start, decrypt, k_ready;
   logic [64:1] key;
   logic [48:1] k_out;
   logic        k_valid, busy, done, key_err;
   logic [3:0]  round;

   exp_t exp_q [$];
   int   checks = 0;
   int   errors = 0;
   int   xfers  = 0;

   des_key_sched dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .key     (key),
      .decrypt (decrypt),
      .K       (k_out),
      .k_valid (k_valid),
      .k_ready (k_ready),
      .round   (round),
      .busy    (busy),
      .done    (done),
      .key_err (key_err)
   );

   always #5 clk = ~clk;

   // Subkey r = PC-2 of PC-1(key) with each half rotated left by the total shift to round r.
   function automatic logic [48:1] ref_subkey(input logic [64:1] kk, input int r);
      logic [56:1] cd0;
      logic [48:1] res;
      int          tot, p, src;
      tot = 0;
      for (int i = 0; i < r; i++) tot += SH_T[i];
      for (int i = 1; i <= 56; i++) cd0[57-i] = kk[65-PC1_T[i-1]];
      for (int n = 1; n <= 48; n++) begin
         p   = PC2_T[n-1];
         src = (p <= 28) ? ((p - 1 + tot) % 28) + 1 : ((p - 29 + tot) % 28) + 29;
         res[49-n] = cd0[57-src];
      end
      return res;
   endfunction

   function automatic logic [64:1] fix_parity(input logic [64:1] kk);
      logic [64:1] v;
      v = kk;
      for (int b = 0; b < 8; b++) v[8*b+1] = ~^v[8*b+2 +: 7];
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic push_run(input logic [64:1] kk, input logic dec);
      for (int i = 1; i <= 16; i++) begin
         int   r;
         exp_t e;
         r   = dec ? 17 - i : i;
         e.k = ref_subkey(kk, r);
         e.r = 4'(r % 16);
         exp_q.push_back(e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_start(input logic [64:1] kk, input logic dec);
      start   = 1'b1;
      key     = kk;
      decrypt = dec;
      tick();
      start = 1'b0;
   endtask

   task automatic run_to_idle(input bit random_ready, input int budget);
      int n;
      int stall;
      n     = 0;
      stall = 0;
      while (busy && n < budget) begin
         if (random_ready) begin
            if (stall > 0) begin
               k_ready = 1'b0;
               stall--;
            end else if ($urandom_range(7) == 0) begin
               k_ready = 1'b0;
               stall   = 9;
            end else begin
               k_ready = 1'($urandom_range(1));
            end
         end
         tick();
         n++;
      end
      k_ready = 1'b1;
      check("run_completes_busy", busy, 0);
      check("queue_drained", exp_q.size(), 0);
   endtask

   always @(negedge clk) begin
      if (!rst && k_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_subkey: got K=%0h round=%0d expected no valid", k_out, round);
         end else begin
            check("subkey_K", k_out, exp_q[0].k);
            check("subkey_round", round, exp_q[0].r);
            if (k_ready) begin
               void'(exp_q.pop_front());
               xfers++;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected test end");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n, x0, dseen;
      logic [64:1] rk;
      logic        rd;

      rst = 1'b1; start = 1'b0; decrypt = 1'b0; k_ready = 1'b0; key = '0;
      #3;
      check("rst_K", k_out, 0);
      check("rst_round", round, 0);
      check("rst_kvalid", k_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_keyerr", key_err, 0);
      tick();
      rst = 1'b0;
      tick();
      check("idle_busy", busy, 0);

      // Encrypt with ready held high; restart in decrypt during the done cycle.
      k_ready = 1'b1;
      push_run(KEY, 1'b0);
      issue_start(KEY, 1'b0);
      check("enc_first_K", k_out, SK1);
      check("enc_first_round", round, 1);
      check("enc_first_valid", k_valid, 1);
      n = 1;
      while (!done && n < 40) begin
         if (n == 16) begin
            check("enc_last_K", k_out, SK16);
            check("enc_last_round", round, 0);
         end
         tick();
         n++;
      end
      check("done_cycle", n, 17);
      check("done_busy", busy, 0);
      check("done_kvalid", k_valid, 0);
      push_run(KEY, 1'b1);
      issue_start(KEY, 1'b1);
      check("done_one_cycle", done, 0);
      check("restart_busy", busy, 1);
      check("dec_first_K", k_out, SK16);
      check("dec_first_round", round, 0);
      run_to_idle(1'b0, 40);

      // Random keys and direction with random ready and 10-cycle stalls.
      for (int t = 0; t < 5; t++) begin
         rk = (t == 0) ? KEY : fix_parity({$urandom, $urandom});
         rd = (t == 0) ? 1'b0 : 1'($urandom_range(1));
         x0 = xfers;
         push_run(rk, rd);
         issue_start(rk, rd);
         run_to_idle(1'b1, 800);
         check("transfer_count", xfers - x0, 16);
         tick();
      end

      // Start at round 7 is ignored; reset at round 9 clears outputs asynchronously.
      k_ready = 1'b1;
      push_run(KEY, 1'b0);
      issue_start(KEY, 1'b0);
      repeat (6) tick();
      start = 1'b1; key = fix_parity(64'h0E329232EA6D0D73); decrypt = 1'b1;
      tick();
      start = 1'b0;
      check("ignored_start_busy", busy, 1);
      check("ignored_start_round", round, 8);
      tick();
      #1 rst = 1'b1;
      #1;
      check("async_rst_K", k_out, 0);
      check("async_rst_round", round, 0);
      check("async_rst_kvalid", k_valid, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_done", done, 0);
      exp_q.delete();
      tick();
      rst = 1'b0;
      dseen = 0;
      repeat (20) begin
         tick();
         if (done) dseen++;
      end
      check("no_done_after_reset", dseen, 0);

      // Start on the same edge as the 16th transfer is ignored.
      push_run(KEY, 1'b0);
      issue_start(KEY, 1'b0);
      repeat (15) tick();
      start = 1'b1; key = KEY; decrypt = 1'b0;
      tick();
      start = 1'b0;
      check("last_xfer_start_done", done, 1);
      check("last_xfer_start_busy", busy, 0);
      tick();
      check("last_xfer_start_ignored", busy, 0);

`ifdef DES_KS_PARITY_CHECK_EN
      issue_start(BAD_KEY, 1'b0);
      check("parity_err_flag", key_err, 1);
      check("parity_err_busy", busy, 0);
      tick();
      check("parity_err_sticky", key_err, 1);
      push_run(KEY, 1'b0);
      issue_start(KEY, 1'b0);
      check("parity_err_cleared", key_err, 0);
      check("parity_good_busy", busy, 1);
      run_to_idle(1'b0, 40);
`else
      push_run(BAD_KEY, 1'b0);
      issue_start(BAD_KEY, 1'b0);
      check("parity_ignored_err", key_err, 0);
      check("parity_ignored_K", k_out, SK1);
      run_to_idle(1'b0, 40);
`endif

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
